// File: rtl/dmem_dual_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_dual_issue_arbiter
//  Description : Shares the single-port data memory between the two M-stage
//                lanes. Single-lane accesses pass straight through. A
//                same-cycle access from both lanes is serialised over two
//                cycles, lane 0 first. The pipeline stalls for one cycle and
//                lane 0's read data is held for the second cycle.
//  Options     : DMEM_ARB_PERF_CNT_EN - adds a saturating collision counter
//                output (collision_cnt_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_dual_issue_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l0_valid_i,
    input  logic                  l0_we_i,
    input  logic [CTRL_WIDTH-1:0] l0_ctrl_i,
    input  logic [ADDR_WIDTH-1:0] l0_addr_i,
    input  logic [DATA_WIDTH-1:0] l0_wdata_i,
    input  logic                  l1_valid_i,
    input  logic                  l1_we_i,
    input  logic [CTRL_WIDTH-1:0] l1_ctrl_i,
    input  logic [ADDR_WIDTH-1:0] l1_addr_i,
    input  logic [DATA_WIDTH-1:0] l1_wdata_i,
    output logic [DATA_WIDTH-1:0] l0_rdata_o,
    output logic [DATA_WIDTH-1:0] l1_rdata_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [CTRL_WIDTH-1:0] mem_ctrl_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           collision_cnt_o
`endif
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_rd0_q;

    logic                  w_collision;
    logic                  w_stall;
    logic                  w_we;

    // Both lanes present in a fresh cycle: lane 0 goes now, lane 1 next cycle
    assign w_collision = (r_state == IDLE) && l0_valid_i && l1_valid_i;

    // Memory port steering and read-data return for the current cycle
    always_comb begin
        mem_addr_o  = l0_addr_i;
        mem_ctrl_o  = l0_ctrl_i;
        mem_wdata_o = l0_wdata_i;
        w_we        = 1'b0;
        w_stall     = 1'b0;
        l0_rdata_o  = '0;
        l1_rdata_o  = '0;
        case (r_state)
            IDLE: begin
                if (l0_valid_i) begin
                    w_we       = l0_we_i;
                    l0_rdata_o = mem_rdata_i;
                    w_stall    = l1_valid_i;
                end else if (l1_valid_i) begin
                    mem_addr_o  = l1_addr_i;
                    mem_ctrl_o  = l1_ctrl_i;
                    mem_wdata_o = l1_wdata_i;
                    w_we        = l1_we_i;
                    l1_rdata_o  = mem_rdata_i;
                end
            end
            SECOND: begin
                // Lane 1 inputs are still held by last cycle's stall; a
                // dropped l1_valid_i means lane 1 was flushed meanwhile.
                mem_addr_o  = l1_addr_i;
                mem_ctrl_o  = l1_ctrl_i;
                mem_wdata_o = l1_wdata_i;
                w_we        = l1_valid_i && l1_we_i;
                l0_rdata_o  = r_rd0_q;
                l1_rdata_o  = l1_valid_i ? mem_rdata_i : '0;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Reset must not freeze the pipeline nor corrupt memory, even mid-access
    assign stall_o  = w_stall && rst_n;
    assign mem_we_o = w_we && rst_n;

    // Two-state sequencer plus capture of lane 0 read data on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rd0_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_collision) begin
                        r_state <= SECOND;
                        r_rd0_q <= mem_rdata_i;
                    end
                end
                SECOND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_collision_cnt;

    // Saturating count of IDLE->SECOND transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision_cnt <= '0;
        end else if (w_collision && (r_collision_cnt != c_CNT_MAX)) begin
            r_collision_cnt <= r_collision_cnt + 32'd1;
        end
    end

    assign collision_cnt_o = r_collision_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_dual_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_dual_issue_arbiter
//  Description : Self-checking bench for dmem_dual_issue_arbiter. A simple
//                word memory sits behind the arbiter; a transaction-level
//                reference memory, updated in program order (lane 0 then
//                lane 1), supplies every expected read value.
//  Options     : DMEM_ARB_PERF_CNT_EN - also checks collision_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_dual_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l0_valid_i, l0_we_i, l1_valid_i, l1_we_i;
    logic [2:0]  l0_ctrl_i, l1_ctrl_i;
    logic [31:0] l0_addr_i, l0_wdata_i, l1_addr_i, l1_wdata_i;
    logic [31:0] l0_rdata_o, l1_rdata_o;
    logic        stall_o;
    logic [31:0] mem_addr_o;
    logic [2:0]  mem_ctrl_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] collision_cnt_o;
`endif

    dmem_dual_issue_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .CTRL_WIDTH (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .l0_valid_i  (l0_valid_i),
        .l0_we_i     (l0_we_i),
        .l0_ctrl_i   (l0_ctrl_i),
        .l0_addr_i   (l0_addr_i),
        .l0_wdata_i  (l0_wdata_i),
        .l1_valid_i  (l1_valid_i),
        .l1_we_i     (l1_we_i),
        .l1_ctrl_i   (l1_ctrl_i),
        .l1_addr_i   (l1_addr_i),
        .l1_wdata_i  (l1_wdata_i),
        .l0_rdata_o  (l0_rdata_o),
        .l1_rdata_o  (l1_rdata_o),
        .stall_o     (stall_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ctrl_o  (mem_ctrl_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
`ifdef DMEM_ARB_PERF_CNT_EN
        ,
        .collision_cnt_o (collision_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write at rising edge
    logic [31:0] tb_mem [0:255];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E37_79B9 * i) ^ 32'h1234_5678;
    endfunction

    assign mem_rdata_i = tb_mem[mem_addr_o[9:2]];

    // Preload on the first edge, then commit stores from the arbiter
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (mem_we_o) begin
            tb_mem[mem_addr_o[9:2]] <= mem_wdata_o;
        end
    end

    // Reference: architectural memory contents and collision count
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag);
`ifdef DMEM_ARB_PERF_CNT_EN
        check(tag, collision_cnt_o, exp_cnt);
`endif
    endtask

    // One M-stage issue. mode: 0 normal, 1 lane 1 flushed in the second
    // cycle of a collision, 2 reset asserted in the second cycle.
    task automatic txn(input bit v0, input bit we0, input logic [2:0] c0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input bit v1, input bit we1, input logic [2:0] c1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input int mode);
        logic [31:0] held0;
        @(posedge clk); #1;
        l0_valid_i = v0; l0_we_i = we0; l0_ctrl_i = c0; l0_addr_i = a0; l0_wdata_i = d0;
        l1_valid_i = v1; l1_we_i = we1; l1_ctrl_i = c1; l1_addr_i = a1; l1_wdata_i = d1;
        @(negedge clk);
        if (v0 && v1) begin
            held0 = ref_mem[a0[9:2]];
            check("col_stall", stall_o, 1);
            check("col_addr", mem_addr_o, a0);
            check("col_ctrl", mem_ctrl_o, c0);
            check("col_we", mem_we_o, we0);
            check("col_wdata", mem_wdata_o, d0);
            check("col_l0_rdata", l0_rdata_o, held0);
            check("col_l1_rdata", l1_rdata_o, 0);
            if (we0) ref_mem[a0[9:2]] = d0;
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
            @(posedge clk); #1;
            check_cnt("cnt_after_col");
            if (mode == 2) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst2_stall", stall_o, 0);
                check("rst2_we", mem_we_o, 0);
                exp_cnt = 0;
                check_cnt("cnt_after_rst");
                @(posedge clk); #1;
                l0_valid_i = 1'b0; l1_valid_i = 1'b0;
                rst_n = 1'b1;
                return;
            end
            if (mode == 1) l1_valid_i = 1'b0;
            @(negedge clk);
            check("sec_stall", stall_o, 0);
            check("sec_addr", mem_addr_o, a1);
            check("sec_ctrl", mem_ctrl_o, c1);
            check("sec_we", mem_we_o, (mode != 1) && we1);
            check("sec_l0_rdata", l0_rdata_o, held0);
            check("sec_l1_rdata", l1_rdata_o, (mode == 1) ? 32'h0 : ref_mem[a1[9:2]]);
            if (mode != 1 && we1) ref_mem[a1[9:2]] = d1;
        end else if (v0) begin
            check("l0_stall", stall_o, 0);
            check("l0_addr", mem_addr_o, a0);
            check("l0_ctrl", mem_ctrl_o, c0);
            check("l0_we", mem_we_o, we0);
            check("l0_rdata", l0_rdata_o, ref_mem[a0[9:2]]);
            check("l0_other", l1_rdata_o, 0);
            if (we0) ref_mem[a0[9:2]] = d0;
        end else if (v1) begin
            check("l1_stall", stall_o, 0);
            check("l1_addr", mem_addr_o, a1);
            check("l1_ctrl", mem_ctrl_o, c1);
            check("l1_we", mem_we_o, we1);
            check("l1_wdata", mem_wdata_o, d1);
            check("l1_rdata", l1_rdata_o, ref_mem[a1[9:2]]);
            check("l1_other", l0_rdata_o, 0);
            if (we1) ref_mem[a1[9:2]] = d1;
        end else begin
            check("none_stall", stall_o, 0);
            check("none_addr", mem_addr_o, a0);
            check("none_we", mem_we_o, 0);
            check("none_l0_rdata", l0_rdata_o, 0);
            check("none_l1_rdata", l1_rdata_o, 0);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return {22'd0, 8'($urandom_range(0, 31)), 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        exp_cnt = 0;

        // Reset with both lanes requesting stores
        rst_n = 1'b0;
        l0_valid_i = 1'b1; l0_we_i = 1'b1; l0_ctrl_i = 3'd2; l0_addr_i = 32'h10; l0_wdata_i = 32'h1;
        l1_valid_i = 1'b1; l1_we_i = 1'b1; l1_ctrl_i = 3'd2; l1_addr_i = 32'h14; l1_wdata_i = 32'h2;
        repeat (2) begin
            @(negedge clk);
            check("rst_stall", stall_o, 0);
            check("rst_we", mem_we_o, 0);
            check_cnt("rst_cnt");
        end
        @(posedge clk); #1;
        l0_valid_i = 1'b0; l1_valid_i = 1'b0;
        rst_n = 1'b1;

        // Single-lane load after store, 0-cycle latency
        txn(1, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        txn(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        check("deadbeef", l0_rdata_o, 32'hDEAD_BEEF);
        // Two loads in one cycle
        txn(1, 1, 3'd2, 32'h100, 32'h1111_1111, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        txn(0, 0, 3'd0, 32'h0, 32'h0, 1, 1, 3'd2, 32'h104, 32'h2222_2222, 0);
        txn(1, 0, 3'd2, 32'h100, 32'h0, 1, 0, 3'd2, 32'h104, 32'h0, 0);
        check("two_loads_l1", l1_rdata_o, 32'h2222_2222);
        // Older store seen by younger same-address load
        txn(1, 1, 3'd2, 32'h200, 32'hCAFE_F00D, 1, 0, 3'd2, 32'h200, 32'h0, 0);
        check("st_ld_order", l1_rdata_o, 32'hCAFE_F00D);
        // Lane 1 store flushed in the second cycle
        txn(1, 0, 3'd2, 32'h104, 32'h0, 1, 1, 3'd2, 32'h300, 32'h0BAD_0BAD, 1);
        txn(1, 0, 3'd2, 32'h300, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        check("flush_mem", l0_rdata_o, init_word(32'h300 >> 2));
        // Collisions, singles, then reset mid-second cycle
        for (int k = 0; k < 3; k++)
            txn(1, 0, 3'd2, 32'h40 + 32'(k * 4), 32'h0, 1, 0, 3'd1, 32'h80, 32'h0, 0);
        txn(1, 0, 3'd0, 32'h44, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        txn(0, 0, 3'd0, 32'h0, 32'h0, 1, 0, 3'd4, 32'h48, 32'h0, 0);
        txn(1, 1, 3'd2, 32'h50, 32'h5555_AAAA, 1, 1, 3'd2, 32'h54, 32'h7777_8888, 2);
        txn(1, 0, 3'd2, 32'h54, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0);
        check("rst_drop_st", l0_rdata_o, init_word(32'h54 >> 2));

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            int md;
            r  = $urandom_range(0, 19);
            md = (r == 0) ? 2 : (r < 3) ? 1 : 0;
            txn(1'($urandom), 1'($urandom), 3'($urandom), rnd_addr(), $urandom,
                1'($urandom), 1'($urandom), 3'($urandom), rnd_addr(), $urandom, md);
        end

        // Let the last store commit, then read back a few words
        for (int k = 0; k < 8; k++)
            txn(1, 0, 3'd2, 32'(k * 4), 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
